// File: rtl/tile_gpu.sv
// rtl/tile_gpu.sv - puzzle-board pixel colour, flashing cursor and move/scramble instruction decoder
module tile_gpu #(
   parameter int GRID_BITS  = 4,
   parameter int COLOR_W    = 3,
   parameter int COORD_W    = 11,
   parameter int ORIGIN_X   = 231,
   parameter int ORIGIN_Y   = 36,
   parameter int AREA       = 480,
   parameter int FLASH_BITS = 25,
   parameter int WRAP       = 1
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic [3:0]             instruction,
   input  logic                   scramble,
   input  logic [2*COORD_W-1:0]   display_addr,
   input  logic [GRID_BITS-1:0]   mapper_pixel_x,
   input  logic [GRID_BITS-1:0]   mapper_pixel_y,
   input  logic [GRID_BITS-1:0]   offset_x,
   input  logic [GRID_BITS-1:0]   offset_y,
   input  logic [COLOR_W-1:0]     pixel_data,
   output logic [2*COORD_W-1:0]   mapper_display_addr,
   output logic [GRID_BITS-1:0]   offset_pos_x,
   output logic [GRID_BITS-1:0]   offset_pos_y,
   output logic [2*GRID_BITS-1:0] pixel_addr,
   output logic [COLOR_W-1:0]     display_data,
   output logic                   ram_write,
   output logic [GRID_BITS-1:0]   ram_write_pos,
   output logic                   ram_write_horizontal,
   output logic                   ram_write_increase,
   output logic [GRID_BITS-1:0]   cursor_x,
   output logic [GRID_BITS-1:0]   cursor_y,
   output logic                   instr_done
);

   localparam logic [GRID_BITS-1:0] MAX_IDX = '1;
   localparam logic [COORD_W:0]     X_LO    = (COORD_W+1)'(ORIGIN_X);
   localparam logic [COORD_W:0]     X_HI    = (COORD_W+1)'(ORIGIN_X + AREA);
   localparam logic [COORD_W:0]     Y_LO    = (COORD_W+1)'(ORIGIN_Y);
   localparam logic [COORD_W:0]     Y_HI    = (COORD_W+1)'(ORIGIN_Y + AREA);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_accept;
   logic                   w_is_move;
   logic                   w_scr_move;
   logic [GRID_BITS-1:0]   r_cursor_x;
   logic [GRID_BITS-1:0]   r_cursor_y;
   logic                   r_cursor_en;
   logic [GRID_BITS-1:0]   w_x_inc;
   logic [GRID_BITS-1:0]   w_x_dec;
   logic [GRID_BITS-1:0]   w_y_inc;
   logic [GRID_BITS-1:0]   w_y_dec;
   logic                   r_ram_write;
   logic [GRID_BITS-1:0]   r_ram_write_pos;
   logic                   r_ram_write_horizontal;
   logic                   r_ram_write_increase;
   logic [FLASH_BITS-1:0]  r_flash_cnt;
   logic                   r_flash_phase;
   logic [COORD_W-1:0]     w_x;
   logic [COORD_W-1:0]     w_y;
   logic                   w_in_area;
   logic                   w_is_cursor;
   logic [GRID_BITS-1:0]   w_row;
   logic [GRID_BITS-1:0]   w_col;
   logic [COLOR_W-1:0]     r_display_data;

   // FSM state register: IDLE waits for an opcode, HOLD waits for its release
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; an opcode executes only once, on the IDLE->HOLD edge
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (instruction >= 4'd1 && instruction <= 4'd6) begin
               w_accept = 1'b1;
               w_next   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instruction == 4'd0) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_is_move  = (instruction >= 4'd1) && (instruction <= 4'd4);
   assign w_scr_move = w_accept & scramble & w_is_move;

   // Edge behaviour of the cursor: wrap around or saturate at the board edge
   assign w_x_inc = (r_cursor_x == MAX_IDX) ? ((WRAP != 0) ? '0 : MAX_IDX) : r_cursor_x + GRID_BITS'(1);
   assign w_x_dec = (r_cursor_x == '0) ? ((WRAP != 0) ? MAX_IDX : '0) : r_cursor_x - GRID_BITS'(1);
   assign w_y_inc = (r_cursor_y == MAX_IDX) ? ((WRAP != 0) ? '0 : MAX_IDX) : r_cursor_y + GRID_BITS'(1);
   assign w_y_dec = (r_cursor_y == '0) ? ((WRAP != 0) ? MAX_IDX : '0) : r_cursor_y - GRID_BITS'(1);

   // Cursor position and enable; moves are ignored here while scrambling
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_cursor_x  <= '0;
         r_cursor_y  <= '0;
         r_cursor_en <= 1'b1;
      end else if (w_accept) begin
         case (instruction)
            4'd1: if (!scramble) r_cursor_y <= w_y_dec;
            4'd2: if (!scramble) r_cursor_x <= w_x_inc;
            4'd3: if (!scramble) r_cursor_x <= w_x_dec;
            4'd4: if (!scramble) r_cursor_y <= w_y_inc;
            4'd5: begin
               r_cursor_x <= '0;
               r_cursor_y <= '0;
            end
            4'd6: r_cursor_en <= ~r_cursor_en;
            default: ;
         endcase
      end
   end

   // Single-cycle tile RAM shift strobe; fields hold their last value between pulses
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_ram_write            <= 1'b0;
         r_ram_write_pos        <= '0;
         r_ram_write_horizontal <= 1'b0;
         r_ram_write_increase   <= 1'b0;
      end else begin
         r_ram_write <= w_scr_move;
         if (w_scr_move) begin
            r_ram_write_horizontal <= (instruction == 4'd2) || (instruction == 4'd3);
            r_ram_write_increase   <= (instruction == 4'd1) || (instruction == 4'd2);
            r_ram_write_pos        <= ((instruction == 4'd2) || (instruction == 4'd3)) ? r_cursor_y : r_cursor_x;
         end
      end
   end

   // Free-running flash counter; the phase flips each time the counter wraps
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_flash_cnt   <= '0;
         r_flash_phase <= 1'b0;
      end else begin
         r_flash_cnt <= r_flash_cnt + FLASH_BITS'(1);
         if (&r_flash_cnt) r_flash_phase <= ~r_flash_phase;
      end
   end

   assign w_x         = display_addr[2*COORD_W-1:COORD_W];
   assign w_y         = display_addr[COORD_W-1:0];
   assign w_in_area   = ({1'b0, w_x} >= X_LO) && ({1'b0, w_x} <= X_HI) &&
                        ({1'b0, w_y} >= Y_LO) && ({1'b0, w_y} <= Y_HI);
   assign w_is_cursor = r_cursor_en & r_flash_phase &
                        (mapper_pixel_x == r_cursor_x) & (mapper_pixel_y == r_cursor_y);
   assign w_row       = mapper_pixel_y + offset_x;
   assign w_col       = mapper_pixel_x + offset_y;

   // Registered pixel colour: black outside the window, inverted on the lit cursor
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset)            r_display_data <= '0;
      else if (!w_in_area)  r_display_data <= '0;
      else if (w_is_cursor) r_display_data <= ~pixel_data;
      else                  r_display_data <= pixel_data;
   end

   assign mapper_display_addr  = display_addr;
   assign offset_pos_x         = mapper_pixel_x;
   assign offset_pos_y         = mapper_pixel_y;
   assign pixel_addr           = {w_row, w_col};
   assign display_data         = r_display_data;
   assign ram_write            = r_ram_write;
   assign ram_write_pos        = r_ram_write_pos;
   assign ram_write_horizontal = r_ram_write_horizontal;
   assign ram_write_increase   = r_ram_write_increase;
   assign cursor_x             = r_cursor_x;
   assign cursor_y             = r_cursor_y;
   assign instr_done           = (r_state == S_HOLD);

endmodule

// File: tb/tb_tile_gpu.sv
// tb/tb_tile_gpu.sv - randomized and directed check of tile_gpu against a behavioural model
module tb_tile_gpu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  instruction = '0;
   logic        scramble = 1'b0;
   logic [10:0] disp_x = '0;
   logic [10:0] disp_y = '0;
   logic [3:0]  mx = '0, my = '0, ox = '0, oy = '0;
   logic [2:0]  pix = '0;

   logic [1:0][21:0] o_mda;
   logic [1:0][3:0]  o_opx, o_opy, o_rwpos, o_cx, o_cy;
   logic [1:0][7:0]  o_paddr;
   logic [1:0][2:0]  o_disp;
   logic [1:0]       o_rw, o_hor, o_inc, o_done;

   int total = 0;
   int bad   = 0;

   // model state, index 0 = wrapping instance, index 1 = clamping instance
   int m_cx[2], m_cy[2], m_en[2], m_busy[2], m_rw[2], m_pos[2], m_hor[2], m_inc[2], m_disp[2];
   int m_n;

   always #5 clk = ~clk;

   tile_gpu #(.FLASH_BITS(3), .WRAP(1)) u_wrap (
      .sysclk(clk), .reset(rst), .instruction(instruction), .scramble(scramble),
      .display_addr({disp_x, disp_y}), .mapper_pixel_x(mx), .mapper_pixel_y(my),
      .offset_x(ox), .offset_y(oy), .pixel_data(pix),
      .mapper_display_addr(o_mda[0]), .offset_pos_x(o_opx[0]), .offset_pos_y(o_opy[0]),
      .pixel_addr(o_paddr[0]), .display_data(o_disp[0]), .ram_write(o_rw[0]),
      .ram_write_pos(o_rwpos[0]), .ram_write_horizontal(o_hor[0]), .ram_write_increase(o_inc[0]),
      .cursor_x(o_cx[0]), .cursor_y(o_cy[0]), .instr_done(o_done[0]));

   tile_gpu #(.FLASH_BITS(3), .WRAP(0)) u_clamp (
      .sysclk(clk), .reset(rst), .instruction(instruction), .scramble(scramble),
      .display_addr({disp_x, disp_y}), .mapper_pixel_x(mx), .mapper_pixel_y(my),
      .offset_x(ox), .offset_y(oy), .pixel_data(pix),
      .mapper_display_addr(o_mda[1]), .offset_pos_x(o_opx[1]), .offset_pos_y(o_opy[1]),
      .pixel_addr(o_paddr[1]), .display_data(o_disp[1]), .ram_write(o_rw[1]),
      .ram_write_pos(o_rwpos[1]), .ram_write_horizontal(o_hor[1]), .ram_write_increase(o_inc[1]),
      .cursor_x(o_cx[1]), .cursor_y(o_cy[1]), .instr_done(o_done[1]));

   function automatic int mv(int v, int d, int wrap);
      int r;
      r = v + d;
      if (r < 0)  r = wrap ? 15 : 0;
      if (r > 15) r = wrap ? 0 : 15;
      return r;
   endfunction

   // behavioural model: one instruction per press, flash phase from elapsed cycles
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_n = 0;
         for (int i = 0; i < 2; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_en[i] = 1; m_busy[i] = 0;
            m_rw[i] = 0; m_pos[i] = 0; m_hor[i] = 0; m_inc[i] = 0; m_disp[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int inwin, cur, op;
            inwin = disp_x >= 231 && disp_x <= 711 && disp_y >= 36 && disp_y <= 516;
            cur = m_en[i] && (((m_n >> 3) & 1) == 1) && mx == m_cx[i] && my == m_cy[i];
            m_disp[i] = !inwin ? 0 : (cur ? (~int'(pix)) & 7 : int'(pix));
            op = int'(instruction);
            m_rw[i] = 0;
            if (m_busy[i]) begin
               if (op == 0) m_busy[i] = 0;
            end else if (op >= 1 && op <= 6) begin
               m_busy[i] = 1;
               if (op <= 4 && scramble) begin
                  m_rw[i]  = 1;
                  m_hor[i] = (op == 2 || op == 3);
                  m_inc[i] = (op == 1 || op == 2);
                  m_pos[i] = m_hor[i] ? m_cy[i] : m_cx[i];
               end else begin
                  case (op)
                     1: m_cy[i] = mv(m_cy[i], -1, i == 0);
                     2: m_cx[i] = mv(m_cx[i], 1, i == 0);
                     3: m_cx[i] = mv(m_cx[i], -1, i == 0);
                     4: m_cy[i] = mv(m_cy[i], 1, i == 0);
                     5: begin m_cx[i] = 0; m_cy[i] = 0; end
                     default: m_en[i] = 1 - m_en[i];
                  endcase
               end
            end
         end
         m_n = m_n + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("cursor_x[%0d]", i), 32'(o_cx[i]), m_cx[i]);
            chk($sformatf("cursor_y[%0d]", i), 32'(o_cy[i]), m_cy[i]);
            chk($sformatf("instr_done[%0d]", i), 32'(o_done[i]), m_busy[i]);
            chk($sformatf("ram_write[%0d]", i), 32'(o_rw[i]), m_rw[i]);
            chk($sformatf("ram_pos[%0d]", i), 32'(o_rwpos[i]), m_pos[i]);
            chk($sformatf("ram_hor[%0d]", i), 32'(o_hor[i]), m_hor[i]);
            chk($sformatf("ram_inc[%0d]", i), 32'(o_inc[i]), m_inc[i]);
            chk($sformatf("display_data[%0d]", i), 32'(o_disp[i]), m_disp[i]);
            chk($sformatf("pixel_addr[%0d]", i), 32'(o_paddr[i]),
                ((int'(my) + int'(ox)) % 16) * 16 + (int'(mx) + int'(oy)) % 16);
            chk($sformatf("mapper_addr[%0d]", i), 32'(o_mda[i]), int'(disp_x) * 2048 + int'(disp_y));
            chk($sformatf("offset_pos[%0d]", i), 32'({o_opx[i], o_opy[i]}), int'(mx) * 16 + int'(my));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_op(input logic [3:0] op, input logic scr);
      instruction = op; scramble = scr; step();
      instruction = 4'd0; step();
   endtask

   initial begin
      int cnt, cnt_inv, cnt_plain;
      fork monitor(); join_none
      step(); step();
      rst = 1'b0;
      disp_x = 11'd300; disp_y = 11'd300;

      // opcode 2 held five cycles: one move, instr_done high five cycles
      cnt = 0;
      instruction = 4'd2;
      for (int k = 0; k < 5; k++) begin step(); cnt += int'(o_done[0]); end
      instruction = 4'd0; step();
      chk("held_move_x", 32'(o_cx[0]), 1);
      chk("held_done_cycles", cnt, 5);
      chk("held_done_low", 32'(o_done[0]), 0);

      // up at y=0 wraps / clamps, down at 15 wraps back
      do_op(4'd5, 1'b0);
      do_op(4'd1, 1'b0);
      chk("wrap_up_y", 32'(o_cy[0]), 15);
      chk("clamp_up_y", 32'(o_cy[1]), 0);
      do_op(4'd4, 1'b0);
      chk("wrap_down_y", 32'(o_cy[0]), 0);

      // window boundary and plain pixel
      do_op(4'd5, 1'b0);
      disp_x = 11'd230; disp_y = 11'd100; pix = 3'b111; step();
      chk("left_of_window", 32'(o_disp[0]), 0);
      disp_x = 11'd231; disp_y = 11'd36; mx = 4'd5; my = 4'd5; pix = 3'b101; step();
      chk("window_corner", 32'(o_disp[0]), 3'b101);

      // flashing cursor on cell (2,2)
      do_op(4'd2, 1'b0); do_op(4'd2, 1'b0); do_op(4'd4, 1'b0); do_op(4'd4, 1'b0);
      disp_x = 11'd400; disp_y = 11'd400; mx = 4'd2; my = 4'd2; pix = 3'b001;
      cnt_inv = 0; cnt_plain = 0;
      step();
      for (int k = 0; k < 32; k++) begin
         step();
         cnt_inv += (o_disp[0] == 3'b110);
         cnt_plain += (o_disp[0] == 3'b001);
      end
      chk("flash_inverted", cnt_inv, 16);
      chk("flash_plain", cnt_plain, 16);
      do_op(4'd6, 1'b0);
      cnt_plain = 0;
      for (int k = 0; k < 32; k++) begin step(); cnt_plain += (o_disp[0] == 3'b001); end
      chk("cursor_off_plain", cnt_plain, 32);
      do_op(4'd6, 1'b0);

      // scramble left at (3,7)
      do_op(4'd5, 1'b0);
      for (int k = 0; k < 3; k++) do_op(4'd2, 1'b0);
      for (int k = 0; k < 7; k++) do_op(4'd4, 1'b0);
      instruction = 4'd3; scramble = 1'b1; step();
      chk("scr_write", 32'(o_rw[0]), 1);
      chk("scr_fields", 32'({o_rwpos[0], o_hor[0], o_inc[0]}), {4'd7, 1'b1, 1'b0});
      chk("scr_cursor", 32'({o_cx[0], o_cy[0]}), {4'd3, 4'd7});
      step();
      chk("scr_one_cycle", 32'(o_rw[0]), 0);
      instruction = 4'd0; scramble = 1'b0; step();

      // async reset during HOLD and a write pulse
      instruction = 4'd2; scramble = 1'b1; step();
      chk("pre_reset_write", 32'(o_rw[0]), 1);
      rst = 1'b1; #1;
      chk("reset_write", 32'(o_rw[0]), 0);
      chk("reset_done", 32'(o_done[0]), 0);
      chk("reset_fields", 32'({o_rwpos[0], o_hor[0], o_inc[0]}), 0);
      chk("reset_cursor", 32'({o_cx[0], o_cy[0]}), 0);
      chk("reset_disp", 32'(o_disp[0]), 0);
      step(); step();
      rst = 1'b0; step();
      chk("reaccept_done", 32'(o_done[0]), 1);
      chk("reaccept_write", 32'(o_rw[0]), 1);
      instruction = 4'd0; scramble = 1'b0; step();

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 2) == 0) instruction = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 1) == 1) instruction = 4'd0;
         scramble = 1'($urandom_range(0, 1));
         disp_x = 11'($urandom_range(220, 720));
         disp_y = 11'($urandom_range(26, 526));
         mx = 4'($urandom); my = 4'($urandom);
         ox = 4'($urandom); oy = 4'($urandom);
         if ($urandom_range(0, 3) == 0) begin mx = o_cx[0]; my = o_cy[0]; end
         pix = 3'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
